// File: rtl/plot_receiver.sv
// Pixel-plot receiver: framebuffer with a raster scan that counts pixels of one colour.
// Define PLOT_RECEIVER_CHECKSUM_EN to add a 16-bit colour-sum checksum over each scan.
module plot_receiver #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  vga_x,
  input  logic [6:0]  vga_y,
  input  logic [2:0]  vga_colour,
  input  logic        vga_plot,
  input  logic        start,
  input  logic [2:0]  match_colour,
  output logic        done,
  output logic        busy,
  output logic [14:0] match_count,
  output logic [7:0]  oor_count,
  output logic [15:0] checksum
);

  localparam int NPIX = SCREEN_W * SCREEN_H;
  localparam int AW = $clog2(NPIX);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   scan_addr_q, scan_addr_d;
  logic            reads_done_q, reads_done_d;
  logic            rd_vld_q, rd_vld_d;
  logic            rd_last_q, rd_last_d;
  logic            acc_last_q, acc_last_d;
  logic [2:0]      mcol_q, mcol_d;
  logic [14:0]     match_q, match_d;
  logic [7:0]      oor_q, oor_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic [2:0]      rd_data_q;
  logic            rd_en;
  logic            in_range;
  logic [AW-1:0]   plot_addr;
  logic [2:0]      fb_mem [NPIX];

  assign in_range  = (32'(vga_x) < SCREEN_W) && (32'(vga_y) < SCREEN_H);
  assign plot_addr = AW'(vga_y) * AW'(SCREEN_W) + AW'(vga_x);
  assign rd_en     = (state_q == SCAN) && !reads_done_q;

  // Framebuffer is never reset; a same-address write and read returns the old data.
  always_ff @(posedge clk) begin
    if (vga_plot && in_range) fb_mem[plot_addr] <= vga_colour;
    if (rd_en) rd_data_q <= fb_mem[scan_addr_q];
  end

  always_comb begin
    state_d      = state_q;
    scan_addr_d  = scan_addr_q;
    reads_done_d = reads_done_q;
    mcol_d       = mcol_q;
    match_d      = match_q;
    oor_d        = oor_q;
    rd_vld_d     = rd_en;
    rd_last_d    = rd_en && (scan_addr_q == LAST_ADDR);
    acc_last_d   = 1'b0;

    if (vga_plot && !in_range && (oor_q != 8'hFF)) oor_d = oor_q + 8'd1;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = SCAN;
          scan_addr_d  = '0;
          reads_done_d = 1'b0;
          match_d      = '0;
          mcol_d       = match_colour;
        end
      end
      SCAN: begin
        if (rd_en) begin
          scan_addr_d = scan_addr_q + AW'(1);
          if (scan_addr_q == LAST_ADDR) reads_done_d = 1'b1;
        end
        // Read data lags the address by one cycle; the last pixel is summed before DONE.
        if (rd_vld_q) begin
          if (rd_data_q == mcol_q) match_d = match_q + 15'd1;
          acc_last_d = rd_last_q;
        end
        if (acc_last_q) state_d = DONE;
      end
      DONE: begin
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    done_d = (state_d == DONE);
    busy_d = (state_d == SCAN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      scan_addr_q  <= '0;
      reads_done_q <= 1'b0;
      rd_vld_q     <= 1'b0;
      rd_last_q    <= 1'b0;
      acc_last_q   <= 1'b0;
      mcol_q       <= '0;
      match_q      <= '0;
      oor_q        <= '0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      scan_addr_q  <= scan_addr_d;
      reads_done_q <= reads_done_d;
      rd_vld_q     <= rd_vld_d;
      rd_last_q    <= rd_last_d;
      acc_last_q   <= acc_last_d;
      mcol_q       <= mcol_d;
      match_q      <= match_d;
      oor_q        <= oor_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  assign done        = done_q;
  assign busy        = busy_q;
  assign match_count = match_q;
  assign oor_count   = oor_q;

`ifdef PLOT_RECEIVER_CHECKSUM_EN
  logic [15:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if ((state_q == IDLE) && start) csum_d = '0;
    else if ((state_q == SCAN) && rd_vld_q) csum_d = csum_q + {13'd0, rd_data_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) csum_q <= '0;
    else        csum_q <= csum_d;
  end

  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_plot_receiver.sv
// Self-checking bench for plot_receiver on a 160x8 screen; expected scan results
// come from a bench-side framebuffer model and pass through a scoreboard queue.
module tb_plot_receiver;

  localparam int W    = 160;
  localparam int H    = 8;
  localparam int NPIX = W * H;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        start;
  logic [2:0]  match_colour;
  logic        done;
  logic        busy;
  logic [14:0] match_count;
  logic [7:0]  oor_count;
  logic [15:0] checksum;

  typedef struct {
    int mc;
    int cs;
  } exp_t;

  exp_t sb_q[$];
  int   fb_model [NPIX];
  int   oor_exp;
  int   n_checks;
  int   n_fail;

  plot_receiver #(.SCREEN_W(W), .SCREEN_H(H)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vga_x        (vga_x),
    .vga_y        (vga_y),
    .vga_colour   (vga_colour),
    .vga_plot     (vga_plot),
    .start        (start),
    .match_colour (match_colour),
    .done         (done),
    .busy         (busy),
    .match_count  (match_count),
    .oor_count    (oor_count),
    .checksum     (checksum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_count(input logic [2:0] c);
    int n = 0;
    for (int i = 0; i < NPIX; i++) if (fb_model[i] == int'(c)) n++;
    return n;
  endfunction

  function automatic int model_csum();
    int s = 0;
`ifdef PLOT_RECEIVER_CHECKSUM_EN
    for (int i = 0; i < NPIX; i++) s += fb_model[i];
    s = s % 65536;
`endif
    return s;
  endfunction

  task automatic plot(input int x, input int y, input int c);
    vga_x      = 8'(x);
    vga_y      = 7'(y);
    vga_colour = 3'(c);
    vga_plot   = 1'b1;
    if (x < W && y < H) fb_model[y * W + x] = c;
    else if (oor_exp < 255) oor_exp++;
    step();
    vga_plot = 1'b0;
  endtask

  task automatic fill(input int c);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        plot(x, y, c);
  endtask

  // mid >= 0 plots (0,0) and (10,1) colour 1 while scan address mid is being read.
  task automatic run_scan(input string tag, input logic [2:0] mc, input int mid, input int hold);
    exp_t e;
    int   cyc;
    e.mc = model_count(mc);
    e.cs = model_csum();
    sb_q.push_back(e);
    start        = 1'b1;
    match_colour = mc;
    step();
    chk({tag, "_busy_scan"}, 32'(busy), 32'd1);
    match_colour = ~mc;
    cyc = 0;
    while (!done && cyc < NPIX + 10) begin
      if (mid >= 0) begin
        if (cyc == mid) begin
          vga_x = 8'd0; vga_y = 7'd0; vga_colour = 3'd1; vga_plot = 1'b1;
        end else if (cyc == mid + 1) begin
          vga_x = 8'd10; vga_y = 7'd1;
        end else if (cyc == mid + 2) begin
          vga_plot = 1'b0;
        end
      end
      step();
      cyc++;
    end
    vga_plot = 1'b0;
    chk({tag, "_latency"}, 32'(cyc), 32'(NPIX + 2));
    chk({tag, "_busy_done"}, 32'(busy), 32'd0);
    e = sb_q.pop_front();
    chk({tag, "_match"}, 32'(match_count), 32'(e.mc));
    chk({tag, "_csum"}, 32'(checksum), 32'(e.cs));
    for (int i = 0; i < hold; i++) begin
      step();
      chk({tag, "_hold_done"}, 32'(done), 32'd1);
      chk({tag, "_hold_busy"}, 32'(busy), 32'd0);
    end
    start = 1'b0;
    step();
    chk({tag, "_idle_done"}, 32'(done), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idle_match"}, 32'(match_count), 32'(e.mc));
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    oor_exp = 0;
    for (int i = 0; i < NPIX; i++) fb_model[i] = 0;
    rst_n = 1'b0;
    vga_x = '0; vga_y = '0; vga_colour = '0; vga_plot = 1'b0;
    start = 1'b0; match_colour = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_match", 32'(match_count), 32'd0);
    chk("rst_oor", 32'(oor_count), 32'd0);
    chk("rst_csum", 32'(checksum), 32'd0);
    rst_n = 1'b1;
    step();

    fill(5);
    run_scan("fill101", 3'b101, -1, 0);

    plot(0, 0, 2);
    plot(W - 1, H - 1, 2);
    run_scan("corner010", 3'b010, -1, 0);
    run_scan("corner101", 3'b101, -1, 0);

    fill(0);
    plot(W, 0, 7);
    plot(0, H, 7);
    chk("oor_two", 32'(oor_count), 32'(oor_exp));
    run_scan("oor111", 3'b111, -1, 0);

    for (int i = 0; i < 40; i++)
      plot($urandom_range(W - 1), $urandom_range(H - 1), $urandom_range(7));
    start = 1'b1;
    match_colour = 3'b000;
    step();
    start = 1'b0;
    repeat (600) step();
    #2 rst_n = 1'b0;
    #1;
    oor_exp = 0;
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_match", 32'(match_count), 32'd0);
    chk("abort_oor", 32'(oor_count), 32'd0);
    chk("abort_csum", 32'(checksum), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    run_scan("after_rst0", 3'b000, -1, 0);
    run_scan("after_rstr", 3'($urandom_range(1, 7)), -1, 0);

    fill(0);
    fb_model[1 * W + 10] = 1;
    run_scan("midscan", 3'b001, 100, 3);
    fb_model[0] = 1;
    run_scan("midscan_after", 3'b001, -1, 0);

    for (int i = 0; i < 254; i++) plot((i % 2 == 0) ? 200 : 0, (i % 2 == 0) ? 3 : 127, 7);
    chk("oor_254", 32'(oor_count), 32'(oor_exp));
    for (int i = 0; i < 10; i++) plot(255, 127, 7);
    chk("oor_sat", 32'(oor_count), 32'(oor_exp));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
